// File: rtl/fifo_pkg.sv
// fifo_pkg -- shared constants and helpers for the replay FIFO family.
//   DEFAULT_DEPTH / DEFAULT_WIDTH : default geometry.
//   addr_width(depth)             : ceil(log2(depth)), used to size pointers.
//   ptr_dist(a, b, aw)            : (a - b) modulo 2^(aw+1), i.e. the distance
//                                   between two (aw+1)-bit wrapping pointers,
//                                   returned zero-extended to 32 bits.
package fifo_pkg;

  localparam int DEFAULT_DEPTH = 8;
  localparam int DEFAULT_WIDTH = 8;

  function automatic int addr_width(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < depth) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

  function automatic logic [31:0] ptr_dist(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input int          aw);
    logic [31:0] mask;
    mask = (32'd1 << (aw + 1)) - 32'd1;
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem -- DEPTH x WIDTH storage for the replay FIFO.
//   clk   : rising-edge clock.
//   reset : asynchronous active-low; clears only the read-data register,
//           never the array.
//   we/waddr/wdata : synchronous write port.
//   re/raddr       : read request; rdata is registered and updates one cycle
//                    after re, holding its value otherwise.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int AW    = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rdata_r;

  // Array write port; the array is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; holds the last word when no read is requested.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata_r <= {WIDTH{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/replay_fifo.sv
// replay_fifo -- FIFO whose read side can be rewound to the last commit point.
//   Entries between the mark pointer (m_ptr) and the read pointer (r_ptr) have
//   been read but not released; rewind replays them, commit releases them.
//   clk, reset(async active-low)
//   wr/wdata        : write request and data (rejected when full).
//   rd              : read request; rdata/rvalid follow one cycle later.
//   commit, rewind  : release read entries / replay from the mark.
//   full, empty, almost_full, almost_empty, level, avail : status.
//   overflow, underflow : sticky errors, cleared by clr_err.
module replay_fifo
  import fifo_pkg::*;
#(
  parameter  int DEPTH    = DEFAULT_DEPTH,
  parameter  int WIDTH    = DEFAULT_WIDTH,
  parameter  int AF_LEVEL = DEPTH - 1,
  parameter  int AE_LEVEL = 1,
  localparam int AW       = addr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  input  logic             commit,
  input  logic             rewind,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      level,
  output logic [AW:0]      avail,
  output logic             overflow,
  output logic             underflow,
  input  logic             clr_err
);

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]  w_ptr_r;
  logic [AW:0]  r_ptr_r;
  logic [AW:0]  m_ptr_r;
  logic         rvalid_r;
  logic         overflow_r;
  logic         underflow_r;

  logic         full_s;
  logic         empty_s;
  logic         wr_ok_s;
  logic         rd_ok_s;
  logic         wr_err_s;
  logic         rd_err_s;
  logic [31:0]  level_ext_s;
  logic [31:0]  avail_ext_s;

  // Status is derived from the registered pointers only, so every decision
  // made at an edge sees pre-edge state (a same-cycle commit cannot unblock
  // a write, and a write cannot make a same-cycle read legal).
  assign full_s  = (w_ptr_r[AW] != m_ptr_r[AW]) &&
                   (w_ptr_r[AW-1:0] == m_ptr_r[AW-1:0]);
  assign empty_s = (w_ptr_r == r_ptr_r);

  assign wr_ok_s  = wr && !full_s;
  assign wr_err_s = wr && full_s;
  // rewind overrides the read side completely, including error reporting.
  assign rd_ok_s  = rd && !empty_s && !rewind;
  assign rd_err_s = rd && empty_s && !rewind;

  assign level_ext_s = ptr_dist(32'(w_ptr_r), 32'(m_ptr_r), AW);
  assign avail_ext_s = ptr_dist(32'(w_ptr_r), 32'(r_ptr_r), AW);

  // Pointer, read-valid and sticky error state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_ptr_r     <= {(AW + 1){1'b0}};
      r_ptr_r     <= {(AW + 1){1'b0}};
      m_ptr_r     <= {(AW + 1){1'b0}};
      rvalid_r    <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_ok_s) begin
        w_ptr_r <= w_ptr_r + PTR_ONE;
      end

      if (rewind) begin
        r_ptr_r <= m_ptr_r;
      end else if (rd_ok_s) begin
        r_ptr_r <= r_ptr_r + PTR_ONE;
      end

      // The mark takes the pre-increment read pointer.
      if (commit && !rewind) begin
        m_ptr_r <= r_ptr_r;
      end

      rvalid_r <= rd_ok_s;

      // A new error in the same cycle as clr_err keeps the flag set.
      if (wr_err_s) begin
        overflow_r <= 1'b1;
      end else if (clr_err) begin
        overflow_r <= 1'b0;
      end

      if (rd_err_s) begin
        underflow_r <= 1'b1;
      end else if (clr_err) begin
        underflow_r <= 1'b0;
      end
    end
  end

  fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (wr_ok_s && reset),
    .waddr (w_ptr_r[AW-1:0]),
    .wdata (wdata),
    .re    (rd_ok_s && reset),
    .raddr (r_ptr_r[AW-1:0]),
    .rdata (rdata)
  );

  assign rvalid       = rvalid_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;
  assign full         = full_s;
  assign empty        = empty_s;
  assign level        = level_ext_s[AW:0];
  assign avail        = avail_ext_s[AW:0];
  assign almost_full  = (level_ext_s >= $unsigned(AF_LEVEL));
  assign almost_empty = (avail_ext_s <= $unsigned(AE_LEVEL));

endmodule
